// File: rtl/stream_rr_arbiter.sv
// Packet-granular round-robin merge of NUM_PORTS AXI-Stream slaves onto one master.
// One idle arbitration cycle precedes every packet; the source port is stamped into tuser.
module stream_rr_arbiter #(
    parameter int C_AXIS_DATA_WIDTH  = 256,
    parameter int C_AXIS_TUSER_WIDTH = 128,
    parameter int NUM_PORTS          = 4,
    parameter int SRC_PORT_POS       = 16
) (
    input  logic                                      axis_aclk,
    input  logic                                      axis_reset,
    input  logic [NUM_PORTS*C_AXIS_DATA_WIDTH-1:0]    s_axis_tdata,
    input  logic [NUM_PORTS*C_AXIS_DATA_WIDTH/8-1:0]  s_axis_tkeep,
    input  logic [NUM_PORTS*C_AXIS_TUSER_WIDTH-1:0]   s_axis_tuser,
    input  logic [NUM_PORTS-1:0]                      s_axis_tvalid,
    input  logic [NUM_PORTS-1:0]                      s_axis_tlast,
    output logic [NUM_PORTS-1:0]                      s_axis_tready,
    output logic [C_AXIS_DATA_WIDTH-1:0]              m_axis_tdata,
    output logic [C_AXIS_DATA_WIDTH/8-1:0]            m_axis_tkeep,
    output logic [C_AXIS_TUSER_WIDTH-1:0]             m_axis_tuser,
    output logic                                      m_axis_tvalid,
    output logic                                      m_axis_tlast,
    input  logic                                      m_axis_tready,
    input  logic [NUM_PORTS-1:0]                      cfg_port_enable,
    input  logic                                      cnt_clear,
    output logic [1:0]                                grant_idx,
    output logic                                      busy,
    output logic [31:0]                               pkt_out_cnt
);

    localparam int KW = C_AXIS_DATA_WIDTH / 8;

    typedef enum logic {
        IDLE,
        PASS
    } state_t;

    state_t      state_q, state_d;
    logic [1:0]  rr_ptr_q, rr_ptr_d;
    logic [1:0]  grant_q, grant_d;
    logic [31:0] cnt_q, cnt_d;
    logic        busy_q, busy_d;

    logic [3:0]  req_ext;
    logic [3:0]  tvalid_ext;
    logic [3:0]  tlast_ext;
    logic [3:0]  tready_ext;
    logic        pick_valid;
    logic [1:0]  pick_idx;
    logic        pass;
    logic        last_fire;

    // Zero-extend per-port bit vectors to four so a 2-bit index always fits.
    assign req_ext    = 4'(s_axis_tvalid & cfg_port_enable);
    assign tvalid_ext = 4'(s_axis_tvalid);
    assign tlast_ext  = 4'(s_axis_tlast);

    // Scan rr_ptr, rr_ptr+1, ... ; iterating downward lets the nearest requester win.
    always_comb begin
        // NOTE: every variable gets a default before any branch, so no latch is inferred.
        pick_valid = 1'b0;
        pick_idx   = rr_ptr_q;
        for (int k = NUM_PORTS - 1; k >= 0; k--) begin
            int t;
            t = (int'(rr_ptr_q) + k) % NUM_PORTS;
            if (req_ext[t[1:0]]) begin
                pick_valid = 1'b1;
                pick_idx   = t[1:0];
            end
        end
    end

    // Datapath: a pure mux of the granted port, forced to zero outside PASS or under reset.
    always_comb begin
        pass          = (state_q == PASS) && !axis_reset;
        m_axis_tvalid = 1'b0;
        m_axis_tlast  = 1'b0;
        m_axis_tdata  = '0;
        m_axis_tkeep  = '0;
        m_axis_tuser  = '0;
        tready_ext    = '0;
        if (pass) begin
            m_axis_tvalid = tvalid_ext[grant_q];
            m_axis_tlast  = tlast_ext[grant_q];
            m_axis_tdata  = s_axis_tdata[int'(grant_q)*C_AXIS_DATA_WIDTH +: C_AXIS_DATA_WIDTH];
            m_axis_tkeep  = s_axis_tkeep[int'(grant_q)*KW +: KW];
            m_axis_tuser  = s_axis_tuser[int'(grant_q)*C_AXIS_TUSER_WIDTH +: C_AXIS_TUSER_WIDTH];
            m_axis_tuser[SRC_PORT_POS +: 8] = 8'(8'd1 << {grant_q, 1'b0});
            tready_ext[grant_q] = m_axis_tready;
        end
        s_axis_tready = tready_ext[NUM_PORTS-1:0];
    end

    assign last_fire = m_axis_tvalid && m_axis_tready && m_axis_tlast;

    always_comb begin
        state_d  = state_q;
        rr_ptr_d = rr_ptr_q;
        grant_d  = grant_q;
        cnt_d    = cnt_q;
        unique case (state_q)
            IDLE: begin
                if (pick_valid) begin
                    grant_d = pick_idx;
                    state_d = PASS;
                end
            end
            PASS: begin
                if (last_fire) begin
                    rr_ptr_d = (grant_q == 2'(NUM_PORTS - 1)) ? 2'd0 : grant_q + 2'd1;
                    cnt_d    = cnt_q + 32'd1;
                    state_d  = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        if (cnt_clear) begin
            cnt_d = '0;
        end
        busy_d = (state_d == PASS);
    end

    always_ff @(posedge axis_aclk) begin
        // NOTE: state flops use non-blocking assignments so every flop samples pre-edge values.
        if (axis_reset) begin
            state_q  <= IDLE;
            rr_ptr_q <= '0;
            grant_q  <= '0;
            cnt_q    <= '0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            rr_ptr_q <= rr_ptr_d;
            grant_q  <= grant_d;
            cnt_q    <= cnt_d;
            busy_q   <= busy_d;
        end
    end

    assign grant_idx   = grant_q;
    assign busy        = busy_q;
    assign pkt_out_cnt = cnt_q;

endmodule
